// File: rtl/tau_pkg.sv
// Shared constants and types for the register bank: register indices, FSM states and the
// default data width.
package tau_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE = 8;

  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_B = 3'd1;
  localparam logic [2:0] REG_C = 3'd2;
  localparam logic [2:0] REG_D = 3'd3;
  localparam logic [2:0] REG_E = 3'd4;
  localparam logic [2:0] REG_F = 3'd5;
  localparam logic [2:0] REG_G = 3'd6;
  localparam logic [2:0] REG_H = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    FORCE = 2'd2
  } bank_state_e;

endpackage

// File: rtl/load_hold_buffer.sv
// One-entry holding buffer for a load that lost write-port arbitration to the ALU.
module load_hold_buffer import tau_pkg::*; #(
  parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 drain,
  input  logic                 kill,
  input  logic [2:0]           load_sel,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic                 valid,
  output logic [2:0]           sel,
  output logic [WORD_SIZE-1:0] data
);

  logic                 valid_q;
  logic [2:0]           sel_q;
  logic [WORD_SIZE-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      sel_q   <= load_sel;
      data_q  <= load_data;
    end else if (drain || kill) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign sel   = sel_q;
  assign data  = data_q;

endmodule

// File: rtl/register_bank.sv
// Eight-entry register bank with a single write port shared by ALU writeback and load return;
// colliding loads are parked in a holding buffer and force-drained after STARVE_LIMIT blocks.
module register_bank import tau_pkg::*; #(
  parameter int unsigned WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_wr_en,
  input  logic [2:0]           alu_wr_sel,
  input  logic [WORD_SIZE-1:0] alu_wr_data,
  input  logic                 ld_valid,
  input  logic [2:0]           ld_sel,
  input  logic [WORD_SIZE-1:0] ld_data,
  output logic                 ld_ready,
  output logic                 wb_stall,
  output logic                 load_pending,
  output logic [WORD_SIZE-1:0] reg_a,
  output logic [WORD_SIZE-1:0] reg_b,
  output logic [WORD_SIZE-1:0] reg_c,
  output logic [WORD_SIZE-1:0] reg_d,
  output logic [WORD_SIZE-1:0] reg_e,
  output logic [WORD_SIZE-1:0] reg_f,
  output logic [WORD_SIZE-1:0] reg_g,
  output logic [WORD_SIZE-1:0] reg_h
);

  bank_state_e          state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [4:0]           cnt_inc;
  logic [WORD_SIZE-1:0] regs_q [8];

  logic                 wr_en;
  logic [2:0]           wr_sel;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 ld_accept;

  logic                 buf_load, buf_drain, buf_kill, buf_valid;
  logic [2:0]           buf_sel;
  logic [WORD_SIZE-1:0] buf_data;

  load_hold_buffer #(
    .WORD_SIZE(WORD_SIZE)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .drain    (buf_drain),
    .kill     (buf_kill),
    .load_sel (ld_sel),
    .load_data(ld_data),
    .valid    (buf_valid),
    .sel      (buf_sel),
    .data     (buf_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ld_accept = ld_valid && ld_ready;
  assign cnt_inc   = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_sel    = alu_wr_sel;
    wr_data   = alu_wr_data;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    buf_kill  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        cnt_d = '0;
        if (alu_wr_en) begin
          wr_en = 1'b1;
          // Same-destination load is older than the ALU result, so it is simply dropped.
          if (ld_accept && (alu_wr_sel != ld_sel)) begin
            buf_load = 1'b1;
            state_d  = HELD;
          end
        end else if (ld_accept) begin
          wr_en   = 1'b1;
          wr_sel  = ld_sel;
          wr_data = ld_data;
        end
      end
      HELD: begin
        if (!alu_wr_en) begin
          wr_en     = 1'b1;
          wr_sel    = buf_sel;
          wr_data   = buf_data;
          buf_drain = 1'b1;
          state_d   = EMPTY;
          cnt_d     = '0;
        end else if (alu_wr_sel == buf_sel) begin
          wr_en    = 1'b1;
          buf_kill = 1'b1;
          state_d  = EMPTY;
          cnt_d    = '0;
        end else begin
          wr_en = 1'b1;
          cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_inc[3:0];
          if (cnt_inc == 5'(STARVE_LIMIT)) begin
            state_d = FORCE;
          end
        end
      end
      FORCE: begin
        wr_en     = 1'b1;
        wr_sel    = buf_sel;
        wr_data   = buf_data;
        buf_drain = 1'b1;
        state_d   = EMPTY;
        cnt_d     = '0;
      end
      default: begin
        state_d = EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    load_pending = (state_q == HELD) || (state_q == FORCE);
    ld_ready     = !load_pending;
    wb_stall     = (state_q == FORCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_sel] <= wr_data;
    end
  end

  assign reg_a = regs_q[REG_A];
  assign reg_b = regs_q[REG_B];
  assign reg_c = regs_q[REG_C];
  assign reg_d = regs_q[REG_D];
  assign reg_e = regs_q[REG_E];
  assign reg_f = regs_q[REG_F];
  assign reg_g = regs_q[REG_G];
  assign reg_h = regs_q[REG_H];

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: direct writes, collisions, kill, starvation drain, reset.
module tb_register_bank;

  logic       clk, rst_n;
  logic       alu_wr_en, ld_valid;
  logic [2:0] alu_wr_sel, ld_sel;
  logic [7:0] alu_wr_data, ld_data;
  logic       ld_ready, wb_stall, load_pending;
  logic [7:0] reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h;

  int total  = 0;
  int passed = 0;

  register_bank #(
    .WORD_SIZE   (8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_wr_en   (alu_wr_en),
    .alu_wr_sel  (alu_wr_sel),
    .alu_wr_data (alu_wr_data),
    .ld_valid    (ld_valid),
    .ld_sel      (ld_sel),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .wb_stall    (wb_stall),
    .load_pending(load_pending),
    .reg_a       (reg_a),
    .reg_b       (reg_b),
    .reg_c       (reg_c),
    .reg_d       (reg_d),
    .reg_e       (reg_e),
    .reg_f       (reg_f),
    .reg_g       (reg_g),
    .reg_h       (reg_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_wr_en = 1'b0; alu_wr_sel = 3'd0; alu_wr_data = 8'h00;
    ld_valid  = 1'b0; ld_sel     = 3'd0; ld_data     = 8'h00;
  endtask

  task automatic alu(input logic [2:0] s, input logic [7:0] d);
    alu_wr_en = 1'b1; alu_wr_sel = s; alu_wr_data = d;
  endtask

  task automatic ld(input logic [2:0] s, input logic [7:0] d);
    ld_valid = 1'b1; ld_sel = s; ld_data = d;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_regs", {reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h}, 64'h0);
    check("reset_flags", {61'h0, ld_ready, wb_stall, load_pending}, 64'h4);
    #9 rst_n = 1'b1;
    cyc();

    // Direct ALU write then direct load write.
    alu(3'd3, 8'h5A);
    cyc();
    idle(); ld(3'd6, 8'hC3);
    check("direct_alu_reg_d", reg_d, 8'h5A);
    cyc();
    idle();
    check("direct_ld_reg_g", reg_g, 8'hC3);
    check("direct_ld_pending", load_pending, 1'b0);

    // Collision, different destinations: load parked for one cycle.
    alu(3'd1, 8'h11); ld(3'd2, 8'h22);
    cyc();
    idle();
    check("coll_reg_b", reg_b, 8'h11);
    check("coll_pending", load_pending, 1'b1);
    check("coll_ready", ld_ready, 1'b0);
    check("coll_reg_c_not_yet", reg_c, 8'h00);
    cyc();
    check("coll_drain_reg_c", reg_c, 8'h22);
    check("coll_empty_flags", {ld_ready, load_pending}, 2'b10);

    // Collision, same destination: load dropped.
    alu(3'd4, 8'hAA); ld(3'd4, 8'hBB);
    cyc();
    idle();
    check("same_reg_e", reg_e, 8'hAA);
    check("same_pending", load_pending, 1'b0);
    cyc();
    check("same_reg_e_kept", reg_e, 8'hAA);

    // Kill while HELD.
    alu(3'd0, 8'h01); ld(3'd5, 8'h77);
    cyc();
    idle(); alu(3'd5, 8'h99);
    check("kill_held", load_pending, 1'b1);
    check("kill_reg_a", reg_a, 8'h01);
    cyc();
    idle();
    check("kill_reg_f", reg_f, 8'h99);
    check("kill_pending", load_pending, 1'b0);
    cyc();
    check("kill_reg_f_kept", reg_f, 8'h99);

    // Starvation: buffered load to A, ALU hammers H.
    alu(3'd7, 8'h70); ld(3'd0, 8'h3C);
    cyc();
    idle(); alu(3'd7, 8'h71);
    check("starve_held", load_pending, 1'b1);
    cyc();
    // A load presented while pending must be refused.
    alu(3'd7, 8'h72); ld(3'd1, 8'h55);
    cyc();
    idle(); alu(3'd7, 8'h73);
    check("starve_reg_h_2", reg_h, 8'h72);
    cyc();
    check("starve_no_stall_3", wb_stall, 1'b0);
    alu(3'd7, 8'h74);
    cyc();
    alu(3'd7, 8'hEE);
    check("starve_stall", wb_stall, 1'b1);
    check("starve_stall_flags", {ld_ready, load_pending}, 2'b01);
    check("starve_reg_h_4", reg_h, 8'h74);
    check("starve_reg_a_old", reg_a, 8'h01);
    cyc();
    idle();
    check("force_reg_a", reg_a, 8'h3C);
    check("force_alu_ignored", reg_h, 8'h74);
    check("force_exit_flags", {ld_ready, wb_stall, load_pending}, 3'b100);
    check("refused_ld_reg_b", reg_b, 8'h11);

    // Asynchronous reset with a buffered load.
    alu(3'd2, 8'h0F); ld(3'd3, 8'h33);
    cyc();
    idle(); alu(3'd2, 8'h10);
    check("rst_pre_pending", load_pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_regs", {reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h}, 64'h0);
    check("rst_async_flags", {ld_ready, wb_stall, load_pending}, 3'b100);
    idle();
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    cyc();
    check("rst_load_lost", reg_d, 8'h00);
    check("rst_post_flags", {ld_ready, wb_stall, load_pending}, 3'b100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
